load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 2000, giving the data memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-003 SHALL have port iClk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port iReset, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port iReqValid, input, 1, meaning the execute stage presents a memory request.
REQ-006 SHALL have port oReqReady, output, 1, meaning the unit accepts a request this cycle.
REQ-007 SHALL have port iReqWrite, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port iReqFunct3, input, 3, the RV32I load/store width/sign code.
REQ-009 SHALL have port iReqAddress, input, ADDR_W, the byte address.
REQ-010 SHALL have port iReqWriteData, input, 32, the store data.
REQ-011 SHALL have port oRespValid, output, 1, meaning a response is available.
REQ-012 SHALL have port iRespReady, input, 1, meaning the consumer takes the response.
REQ-013 SHALL have port oRespData, output, 32, the load result (0 for stores).
REQ-014 SHALL have port oRespError, output, 1, meaning an access fault (range or misalignment).
REQ-015 SHALL have memory-side outputs oMemAddress (32), oMemWriteData (32), oMemFunct3 (3), oMemWrite (1) and oMemRead (1).
REQ-016 SHALL have memory-side input iMemReadData, 32.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-018 IDLE: oReqReady=1; a handshake (iReqValid & oReqReady) SHALL latch all request fields and go to ACCESS.
REQ-019 ACCESS SHALL last exactly one cycle: it drives the latched fields to the memory, asserts oMemRead for a load or oMemWrite for a store, captures iMemReadData into the response register, then goes to RESP.
REQ-020 RESP: oRespValid=1 and response fields stable; return to IDLE on iRespReady.
REQ-021 oReqReady SHALL be 0 in ACCESS and RESP (no pipelining).
REQ-022 Latency from request handshake to oRespValid rising SHALL be 2 cycles.
REQ-023 oMemRead and oMemWrite SHALL be 0 outside ACCESS; they SHALL never both be 1.
REQ-024 Legal funct3 SHALL be {000, 001, 010, 100, 101} for loads and {000, 001, 010} for stores; any other code SHALL set oRespError.
REQ-025 Out-of-range access: a request whose address plus access size minus one is ≥ MEM_BYTES (computed at 33-bit width, so no wrap) SHALL set oRespError.
REQ-026 On a faulting request (REQ-024, REQ-025, and REQ-032 when enabled), the unit SHALL skip the memory strobe in ACCESS, force oRespData to 0, and still pass through RESP.
REQ-027 A load SHALL return iMemReadData unchanged; sign and zero extension are the memory's job.
REQ-028 If iRespReady is already high when RESP is entered, RESP SHALL last exactly one cycle.

Reset
REQ-029 iReset SHALL force IDLE; oReqReady=1, oRespValid=0, oRespError=0, oRespData=0, oMemRead=0, oMemWrite=0, oMemAddress=0, oMemWriteData=0, oMemFunct3=0.
REQ-030 Reset during ACCESS SHALL suppress that cycle's memory strobe, so no partial store occurs.
REQ-031 Reset during RESP SHALL discard the pending response.

Configuration
REQ-032 With LSU_MISALIGN_TRAP_EN defined: halfword accesses with addr[0]≠0 and word accesses with addr[1:0]≠0 SHALL fault per REQ-026.
REQ-033 Without LSU_MISALIGN_TRAP_EN: misaligned accesses SHALL pass to memory unchanged and SHALL not raise oRespError.

Structure
REQ-034 A shared package lsu_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the FSM state encoding.
REQ-035 One sub-module, lsu_access_check, SHALL combinationally produce the range, funct3 and misalignment fault flags.

Verification
REQ-036 Store then load: SW 0xDEADBEEF @0x10, then LW @0x10 -> oRespData=0xDEADBEEF; oRespValid 2 cycles after each handshake; no error.
REQ-037 Range fault: LW @1998 -> oRespError=1, oRespData=0, oMemRead never asserted.
REQ-038 Misalignment: LH @0x11 -> with the macro defined, error=1 and no strobe; without it, error=0 and oMemRead pulses once.
REQ-039 Backpressure: iRespReady held low 5 cycles -> oRespValid and oRespData stable, oReqReady=0 throughout.
REQ-040 Reset mid-op: iReset asserted in ACCESS of SB 0xAA @0x20 -> oMemWrite=0 that cycle; a subsequent LBU @0x20 returns the prior contents.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the access-size decode.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsuState_t;

    // Bytes touched by an access; illegal codes fall through to word size.
    function automatic logic [2:0] accessBytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_access_check.sv
// Combinational fault classification of a memory request: range, funct3 legality
// and (when LSU_MISALIGN_TRAP_EN is defined) natural alignment.
module lsu_access_check
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2000,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              iWrite,
    input  logic [2:0]        iFunct3,
    input  logic [ADDR_W-1:0] iAddress,
    output logic              oRangeFault,
    output logic              oFunct3Fault,
    output logic              oMisalignFault
);

    localparam int unsigned EXT_W = ADDR_W + 1;

    logic [EXT_W-1:0] lastByte;

    // One extra bit keeps the last-byte address from wrapping near the top.
    always_comb begin
        lastByte    = {1'b0, iAddress} + EXT_W'(accessBytes(iFunct3)) - EXT_W'(1);
        oRangeFault = (lastByte >= EXT_W'(MEM_BYTES));
    end

    always_comb begin
        if (iWrite) begin
            oFunct3Fault = !(iFunct3 inside {SB, SH, SW});
        end else begin
            oFunct3Fault = !(iFunct3 inside {LB, LH, LW, LBU, LHU});
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        oMisalignFault = 1'b0;
        case (iFunct3[1:0])
            2'b01:   oMisalignFault = iAddress[0];
            2'b10:   oMisalignFault = (iAddress[1:0] != 2'b00);
            default: oMisalignFault = 1'b0;
        endcase
    end
`else
    assign oMisalignFault = 1'b0;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> ACCESS (one memory cycle) -> RESP.
// Build option LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into faults.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2000,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iReqValid,
    output logic              oReqReady,
    input  logic              iReqWrite,
    input  logic [2:0]        iReqFunct3,
    input  logic [ADDR_W-1:0] iReqAddress,
    input  logic [31:0]       iReqWriteData,
    output logic              oRespValid,
    input  logic              iRespReady,
    output logic [31:0]       oRespData,
    output logic              oRespError,
    output logic [31:0]       oMemAddress,
    output logic [31:0]       oMemWriteData,
    output logic [2:0]        oMemFunct3,
    output logic              oMemWrite,
    output logic              oMemRead,
    input  logic [31:0]       iMemReadData
);

    lsuState_t state;
    logic      reqWriteQ;
    logic      faultQ;
    logic      memReadQ;
    logic      memWriteQ;
    logic      rangeFault;
    logic      funct3Fault;
    logic      misalignFault;
    logic      reqFault;

    lsu_access_check #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) uAccessCheck (
        .iWrite         (iReqWrite),
        .iFunct3        (iReqFunct3),
        .iAddress       (iReqAddress),
        .oRangeFault    (rangeFault),
        .oFunct3Fault   (funct3Fault),
        .oMisalignFault (misalignFault)
    );

    assign reqFault = rangeFault | funct3Fault | misalignFault;

    // Strobes are masked by reset so a reset landing in ACCESS never commits a store.
    assign oMemRead  = memReadQ  & ~iReset;
    assign oMemWrite = memWriteQ & ~iReset;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state         <= IDLE;
            oReqReady     <= 1'b1;
            oRespValid    <= 1'b0;
            oRespError    <= 1'b0;
            oRespData     <= 32'd0;
            oMemAddress   <= 32'd0;
            oMemWriteData <= 32'd0;
            oMemFunct3    <= 3'd0;
            memReadQ      <= 1'b0;
            memWriteQ     <= 1'b0;
            reqWriteQ     <= 1'b0;
            faultQ        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iReqValid && oReqReady) begin
                        oReqReady     <= 1'b0;
                        oMemAddress   <= 32'(iReqAddress);
                        oMemWriteData <= iReqWriteData;
                        oMemFunct3    <= iReqFunct3;
                        reqWriteQ     <= iReqWrite;
                        faultQ        <= reqFault;
                        memReadQ      <= !iReqWrite && !reqFault;
                        memWriteQ     <= iReqWrite && !reqFault;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    memReadQ   <= 1'b0;
                    memWriteQ  <= 1'b0;
                    oRespValid <= 1'b1;
                    oRespError <= faultQ;
                    oRespData  <= (faultQ || reqWriteQ) ? 32'd0 : iMemReadData;
                    state      <= RESP;
                end
                RESP: begin
                    if (iRespReady) begin
                        oRespValid <= 1'b0;
                        oReqReady  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    oReqReady <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic checked
// against a byte-array reference model; the bench also plays the data memory.
module tb_load_store_unit;

    localparam int unsigned MEM_BYTES = 2000;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iReqValid;
    logic        oReqReady;
    logic        iReqWrite;
    logic [2:0]  iReqFunct3;
    logic [31:0] iReqAddress;
    logic [31:0] iReqWriteData;
    logic        oRespValid;
    logic        iRespReady;
    logic [31:0] oRespData;
    logic        oRespError;
    logic [31:0] oMemAddress;
    logic [31:0] oMemWriteData;
    logic [2:0]  oMemFunct3;
    logic        oMemWrite;
    logic        oMemRead;
    logic [31:0] iMemReadData;

    load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .iClk          (iClk),
        .iReset        (iReset),
        .iReqValid     (iReqValid),
        .oReqReady     (oReqReady),
        .iReqWrite     (iReqWrite),
        .iReqFunct3    (iReqFunct3),
        .iReqAddress   (iReqAddress),
        .iReqWriteData (iReqWriteData),
        .oRespValid    (oRespValid),
        .iRespReady    (iRespReady),
        .oRespData     (oRespData),
        .oRespError    (oRespError),
        .oMemAddress   (oMemAddress),
        .oMemWriteData (oMemWriteData),
        .oMemFunct3    (oMemFunct3),
        .oMemWrite     (oMemWrite),
        .oMemRead      (oMemRead),
        .iMemReadData  (iMemReadData)
    );

    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;
    int rdTotal = 0;
    int wrTotal = 0;
    int bothTotal = 0;
    logic [31:0] lastData;
    logic        lastErr;
    int          lastRd;
    int          lastWr;

    logic [7:0] devMem [0:MEM_BYTES-1];
    logic [7:0] refMem [0:MEM_BYTES-1];
    logic       devInit = 1'b0;
    logic [7:0] devRd [4];

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 37 + 11) % 256);
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  return {{24{raw[7]}}, raw[7:0]};
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b100:  return {24'd0, raw[7:0]};
            3'b101:  return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic int sizeOf(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Memory device: combinational read with sign/zero extension, byte-lane writes.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (longint'(oMemAddress) + longint'(k) < longint'(MEM_BYTES))
                devRd[k] = devMem[11'(oMemAddress + 32'(k))];
            else
                devRd[k] = 8'h00;
        end
        iMemReadData = extend(oMemFunct3, {devRd[3], devRd[2], devRd[1], devRd[0]});
    end

    always @(posedge iClk) begin
        if (!devInit) begin
            for (int i = 0; i < int'(MEM_BYTES); i++) devMem[i] <= initByte(i);
            devInit <= 1'b1;
        end else if (oMemWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (k < sizeOf(oMemFunct3) &&
                    longint'(oMemAddress) + longint'(k) < longint'(MEM_BYTES))
                    devMem[11'(oMemAddress + 32'(k))] <= oMemWriteData[8*k +: 8];
            end
        end
    end

    // Strobe monitor: tallies every sampled read/write strobe and any overlap.
    always @(negedge iClk) begin
        rdTotal   = rdTotal + int'(oMemRead);
        wrTotal   = wrTotal + int'(oMemWrite);
        bothTotal = bothTotal + int'(oMemRead & oMemWrite);
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: outcome of one request at transaction level, updating refMem on stores.
    function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic expErr, output logic [31:0] expData);
        int         size;
        logic       badF3;
        logic       badRange;
        logic       mis;
        logic [31:0] raw;
        size     = sizeOf(f3);
        badF3    = wr ? !(f3 inside {3'b000, 3'b001, 3'b010})
                      : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        badRange = (longint'(addr) + longint'(size) - 1) >= longint'(MEM_BYTES);
        mis      = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
`endif
        expErr  = badF3 | badRange | mis;
        expData = 32'd0;
        raw     = 32'd0;
        if (!expErr) begin
            if (wr) begin
                for (int k = 0; k < size; k++) refMem[11'(addr + 32'(k))] = wd[8*k +: 8];
            end else begin
                for (int k = 0; k < size; k++) raw[8*k +: 8] = refMem[11'(addr + 32'(k))];
                expData = extend(f3, raw);
            end
        end
    endfunction

    task automatic doReq(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold);
        logic        expErr;
        logic [31:0] expData;
        int          rd0;
        int          wr0;
        int          both0;
        int          expRd;
        int          expWr;
        model(wr, f3, addr, wd, expErr, expData);
        expRd = (!expErr && !wr) ? 1 : 0;
        expWr = (!expErr && wr) ? 1 : 0;
        @(negedge iClk);
        chk("idleReqReady", 32'(oReqReady), 32'd1);
        rd0 = rdTotal; wr0 = wrTotal; both0 = bothTotal;
        iReqValid = 1'b1; iReqWrite = wr; iReqFunct3 = f3;
        iReqAddress = addr; iReqWriteData = wd; iRespReady = (hold == 0);
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        iReqWrite = 1'($urandom); iReqFunct3 = 3'($urandom);
        iReqAddress = $urandom; iReqWriteData = $urandom;
        @(negedge iClk);
        chk("accessReqReady", 32'(oReqReady), 32'd0);
        chk("accessRespValid", 32'(oRespValid), 32'd0);
        @(negedge iClk);
        chk("respValid", 32'(oRespValid), 32'd1);
        chk("respError", 32'(oRespError), 32'(expErr));
        chk("respData", oRespData, expData);
        chk("respReqReady", 32'(oReqReady), 32'd0);
        lastData = oRespData;
        lastErr  = oRespError;
        for (int i = 0; i < hold; i++) begin
            @(negedge iClk);
            chk("holdValid", 32'(oRespValid), 32'd1);
            chk("holdData", oRespData, expData);
            chk("holdError", 32'(oRespError), 32'(expErr));
            chk("holdReqReady", 32'(oReqReady), 32'd0);
        end
        iRespReady = 1'b1;
        @(posedge iClk); #1;
        iRespReady = 1'b0;
        @(negedge iClk);
        chk("doneValid", 32'(oRespValid), 32'd0);
        chk("doneReqReady", 32'(oReqReady), 32'd1);
        lastRd = rdTotal - rd0;
        lastWr = wrTotal - wr0;
        chk("readStrobes", 32'(lastRd), 32'(expRd));
        chk("writeStrobes", 32'(lastWr), 32'(expWr));
        chk("bothStrobes", 32'(bothTotal - both0), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        chk({tag, "_reqReady"}, 32'(oReqReady), 32'd1);
        chk({tag, "_respValid"}, 32'(oRespValid), 32'd0);
        chk({tag, "_respError"}, 32'(oRespError), 32'd0);
        chk({tag, "_respData"}, oRespData, 32'd0);
        chk({tag, "_memRead"}, 32'(oMemRead), 32'd0);
        chk({tag, "_memWrite"}, 32'(oMemWrite), 32'd0);
        chk({tag, "_memAddress"}, oMemAddress, 32'd0);
        chk({tag, "_memWriteData"}, oMemWriteData, 32'd0);
        chk({tag, "_memFunct3"}, 32'(oMemFunct3), 32'd0);
    endtask

    task automatic resetMidStore(input logic [31:0] addr, input logic [7:0] val);
        int wr0;
        @(negedge iClk);
        wr0 = wrTotal;
        iReqValid = 1'b1; iReqWrite = 1'b1; iReqFunct3 = 3'b000;
        iReqAddress = addr; iReqWriteData = {24'd0, val}; iRespReady = 1'b1;
        @(posedge iClk); #1;
        iReqValid = 1'b0; iReset = 1'b1;
        @(negedge iClk);
        chk("resetAccessMemWrite", 32'(oMemWrite), 32'd0);
        @(posedge iClk); #1;
        iReset = 1'b0; iRespReady = 1'b0;
        @(negedge iClk);
        checkResetState("afterResetAccess");
        chk("resetAccessNoStore", 32'(wrTotal - wr0), 32'd0);
    endtask

    task automatic resetMidResp(input logic [31:0] addr);
        @(negedge iClk);
        iReqValid = 1'b1; iReqWrite = 1'b0; iReqFunct3 = 3'b010;
        iReqAddress = addr; iReqWriteData = 32'd0; iRespReady = 1'b0;
        @(posedge iClk); #1;
        iReqValid = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        chk("preResetRespValid", 32'(oRespValid), 32'd1);
        iReset = 1'b1;
        @(posedge iClk); #1;
        iReset = 1'b0;
        @(negedge iClk);
        checkResetState("afterResetResp");
    endtask

    initial begin
        logic [31:0] addr;
        logic [2:0]  f3;
        int          sel;
        for (int i = 0; i < int'(MEM_BYTES); i++) refMem[i] = initByte(i);
        iReset = 1'b1; iReqValid = 1'b0; iReqWrite = 1'b0; iReqFunct3 = 3'd0;
        iReqAddress = 32'd0; iReqWriteData = 32'd0; iRespReady = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        checkResetState("reset");
        #1 iReset = 1'b0;

        doReq(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        doReq(1'b0, 3'b010, 32'h10, 32'd0, 0);
        chk("swLwLiteralData", lastData, 32'hDEADBEEF);
        chk("swLwLiteralErr", 32'(lastErr), 32'd0);

        doReq(1'b0, 3'b010, 32'd1998, 32'd0, 0);
        chk("rangeLiteralErr", 32'(lastErr), 32'd1);
        chk("rangeLiteralData", lastData, 32'd0);
        chk("rangeLiteralNoRead", 32'(lastRd), 32'd0);

        doReq(1'b0, 3'b001, 32'h11, 32'd0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("misalignLiteralErr", 32'(lastErr), 32'd1);
        chk("misalignLiteralRead", 32'(lastRd), 32'd0);
`else
        chk("misalignLiteralErr", 32'(lastErr), 32'd0);
        chk("misalignLiteralRead", 32'(lastRd), 32'd1);
`endif

        doReq(1'b1, 3'b010, 32'h40, 32'h12345678, 5);
        doReq(1'b0, 3'b100, 32'h41, 32'd0, 5);
        chk("backpressureLbuLiteral", lastData, 32'h00000056);

        resetMidStore(32'h20, 8'hAA);
        doReq(1'b0, 3'b100, 32'h20, 32'd0, 0);
        chk("resetStoreLiteral", lastData, 32'h000000AB);

        resetMidResp(32'h10);
        doReq(1'b0, 3'b010, 32'hFFFFFFFE, 32'd0, 1);
        chk("wrapLiteralErr", 32'(lastErr), 32'd1);
        doReq(1'b0, 3'b000, 32'd1999, 32'd0, 0);
        chk("lastByteLiteralErr", 32'(lastErr), 32'd0);

        for (int n = 0; n < 120; n++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       addr = 32'($urandom_range(0, MEM_BYTES - 1));
                1:       addr = 32'(MEM_BYTES - 4) + 32'($urandom_range(0, 7));
                2:       addr = $urandom;
                default: addr = 32'($urandom_range(0, 63)) & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 9) < 8)
                f3 = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5));
            else
                f3 = 3'($urandom);
            doReq(1'($urandom), f3, addr, $urandom, int'($urandom_range(0, 3)));
        end

        chk("neverBothStrobes", 32'(bothTotal), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
